// File: rtl/dt_rr_if.sv
// Bundled packet ports of the round-robin scheduler: four ingress lanes,
// five egress lanes with per-lane ready, plus drop counter and busy status.
interface dt_rr_if #(
  parameter int DCW = 8
);
  logic [19:0]    in_n0, in_n1, in_n2, in_n3;
  logic           in_rdy_n0, in_rdy_n1, in_rdy_n2, in_rdy_n3;
  logic [17:0]    out_n0, out_n1, out_n2, out_n3, out_n4;
  logic           out_rdy_n0, out_rdy_n1, out_rdy_n2, out_rdy_n3, out_rdy_n4;
  logic [DCW-1:0] drop_cnt;
  logic           busy;

  modport master (
    output in_n0, in_n1, in_n2, in_n3,
    output out_rdy_n0, out_rdy_n1, out_rdy_n2, out_rdy_n3, out_rdy_n4,
    input  in_rdy_n0, in_rdy_n1, in_rdy_n2, in_rdy_n3,
    input  out_n0, out_n1, out_n2, out_n3, out_n4,
    input  drop_cnt, busy
  );

  modport slave (
    input  in_n0, in_n1, in_n2, in_n3,
    input  out_rdy_n0, out_rdy_n1, out_rdy_n2, out_rdy_n3, out_rdy_n4,
    output in_rdy_n0, in_rdy_n1, in_rdy_n2, in_rdy_n3,
    output out_n0, out_n1, out_n2, out_n3, out_n4,
    output drop_cnt, busy
  );
endinterface

// File: rtl/dt_rr_scheduler.sv
// Lossless 4-in/5-out packet scheduler: per-source FIFOs, per-destination
// round-robin arbitration over FIFO heads, registered egress with backpressure.
module dt_rr_scheduler #(
  parameter int DEPTH = 2,
  parameter int DCW   = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  dt_rr_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0][19:0] in_s;
  logic [4:0]       out_rdy_s;

  logic [18:0]      mem_q [4][DEPTH];
  logic [AW-1:0]    wr_q [4];
  logic [AW-1:0]    wr_d [4];
  logic [AW-1:0]    rd_q [4];
  logic [AW-1:0]    rd_d [4];
  logic [CW-1:0]    cnt_q [4];
  logic [CW-1:0]    cnt_d [4];
  logic [4:0][1:0]  ptr_q, ptr_d;
  logic [4:0][17:0] out_q, out_d;
  logic [DCW-1:0]   drop_q, drop_d;
  logic [DCW:0]     drop_sum_s;
  logic [2:0]       ndrop_s;
  logic [3:0]       rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [3:0]       push_s, pop_s, drop_s;
  logic [3:0][2:0]  head_dest_s;
  logic [3:0][15:0] head_data_s;
  logic [4:0][3:0]  cand_s;

  assign in_s      = {bus.in_n3, bus.in_n2, bus.in_n1, bus.in_n0};
  assign out_rdy_s = {bus.out_rdy_n4, bus.out_rdy_n3, bus.out_rdy_n2,
                      bus.out_rdy_n1, bus.out_rdy_n0};

  assign bus.in_rdy_n0 = rdy_q[0];
  assign bus.in_rdy_n1 = rdy_q[1];
  assign bus.in_rdy_n2 = rdy_q[2];
  assign bus.in_rdy_n3 = rdy_q[3];
  assign bus.out_n0    = out_q[0];
  assign bus.out_n1    = out_q[1];
  assign bus.out_n2    = out_q[2];
  assign bus.out_n3    = out_q[3];
  assign bus.out_n4    = out_q[4];
  assign bus.drop_cnt  = drop_q;
  assign bus.busy      = busy_q;

  // Heads, accept/drop qualification and per-destination candidate sets.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head_dest_s[i] = mem_q[i][rd_q[i]][18:16];
      head_data_s[i] = mem_q[i][rd_q[i]][15:0];
      push_s[i]      = in_s[i][19] & rdy_q[i] & (in_s[i][18:16] <= 3'd4);
      drop_s[i]      = in_s[i][19] & rdy_q[i] & (in_s[i][18:16] >  3'd4);
    end
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        cand_s[k][i] = (cnt_q[i] != CW'(0)) & (head_dest_s[i] == 3'(k));
      end
    end
  end

  // Round-robin grant per output; a held slot blocks its own grant only.
  always_comb begin
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    pop_s = 4'b0000;
    ptr_d = ptr_q;
    out_d = out_q;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      win   = 2'd0;
      for (int o = 0; o < 4; o++) begin
        idx = ptr_q[k] + 2'(o);
        if (!found && cand_s[k][idx]) begin
          found = 1'b1;
          win   = idx;
        end else begin
          found = found;
        end
      end
      if (((out_q[k][17:16] == 2'b00) || out_rdy_s[k]) && found) begin
        out_d[k]   = {(((cand_s[k] & (cand_s[k] - 4'd1)) != 4'd0) ? 2'b10 : 2'b01),
                      head_data_s[win]};
        ptr_d[k]   = win + 2'd1;
        pop_s[win] = 1'b1;
      end else if (out_rdy_s[k]) begin
        out_d[k] = 18'h0;
      end else begin
        out_d[k] = out_q[k];
      end
    end
  end

  // FIFO pointers, occupancy, saturating drop count and status next-state.
  always_comb begin
    ndrop_s = 3'd0;
    busy_d  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_d[i]  = wr_q[i] + AW'(push_s[i]);
      rd_d[i]  = rd_q[i] + AW'(pop_s[i]);
      cnt_d[i] = cnt_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
      rdy_d[i] = (cnt_d[i] < CW'(DEPTH));
      ndrop_s  = ndrop_s + 3'(drop_s[i]);
      if (cnt_d[i] != CW'(0)) begin
        busy_d = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (out_d[k][17:16] != 2'b00) begin
        busy_d = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    drop_sum_s = {1'b0, drop_q} + (DCW+1)'(ndrop_s);
    drop_d     = drop_sum_s[DCW] ? {DCW{1'b1}} : drop_sum_s[DCW-1:0];
  end

  // State registers; reset empties every FIFO and discards held packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ptr_q  <= '0;
      out_q  <= '0;
      drop_q <= '0;
      rdy_q  <= 4'b1111;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q  <= ptr_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  // Packet storage; contents are meaningless unless covered by the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_q[i]] <= in_s[i][18:0];
      end
    end
  end
endmodule

// File: tb/tb_dt_rr_scheduler.sv
// Scoreboard bench for dt_rr_scheduler: a queue-based reference model predicts
// every egress packet; a monitor process pops and compares what the DUT shows.
module tb_dt_rr_scheduler;
  localparam int DEPTH = 2;
  localparam int DCW   = 8;
  localparam int DMAX  = 255;

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] drv_in [4];
  logic        drv_rdy [5];
  logic [17:0] dut_out [5];
  logic        dut_irdy [4];

  int checks = 0;
  int failures = 0;

  pkt_t        mq [4][$];
  int          mptr [5];
  bit          mslot [5];
  int          mdrop;
  logic [17:0] expq [5][$];

  dt_rr_if #(.DCW(DCW)) bus ();

  dt_rr_scheduler #(.DEPTH(DEPTH), .DCW(DCW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.in_n0 = drv_in[0];
  assign bus.in_n1 = drv_in[1];
  assign bus.in_n2 = drv_in[2];
  assign bus.in_n3 = drv_in[3];
  assign bus.out_rdy_n0 = drv_rdy[0];
  assign bus.out_rdy_n1 = drv_rdy[1];
  assign bus.out_rdy_n2 = drv_rdy[2];
  assign bus.out_rdy_n3 = drv_rdy[3];
  assign bus.out_rdy_n4 = drv_rdy[4];
  assign dut_out[0] = bus.out_n0;
  assign dut_out[1] = bus.out_n1;
  assign dut_out[2] = bus.out_n2;
  assign dut_out[3] = bus.out_n3;
  assign dut_out[4] = bus.out_n4;
  assign dut_irdy[0] = bus.in_rdy_n0;
  assign dut_irdy[1] = bus.in_rdy_n1;
  assign dut_irdy[2] = bus.in_rdy_n2;
  assign dut_irdy[3] = bus.in_rdy_n3;

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    for (int k = 0; k < 5; k++) begin
      mptr[k] = 0;
      mslot[k] = 0;
      expq[k].delete();
    end
    mdrop = 0;
  endfunction

  // Reference: what happens at the coming edge given current inputs.
  function automatic void model_step();
    int sz [4];
    bit popi [4];
    int n, w, s;
    for (int i = 0; i < 4; i++) begin
      sz[i] = mq[i].size();
      popi[i] = 0;
    end
    for (int k = 0; k < 5; k++) begin
      n = 0;
      w = -1;
      for (int o = 0; o < 4; o++) begin
        s = (mptr[k] + o) % 4;
        if (sz[s] > 0 && int'(mq[s][0].dest) == k) begin
          n++;
          if (w < 0) w = s;
        end
      end
      if ((!mslot[k] || drv_rdy[k]) && n > 0) begin
        expq[k].push_back({(n > 1) ? 2'b10 : 2'b01, mq[w][0].data});
        mptr[k] = (w + 1) % 4;
        popi[w] = 1;
        mslot[k] = 1;
      end else if (drv_rdy[k]) begin
        mslot[k] = 0;
      end
    end
    for (int i = 0; i < 4; i++) if (popi[i]) void'(mq[i].pop_front());
    for (int i = 0; i < 4; i++) begin
      if (drv_in[i][19] && sz[i] < DEPTH) begin
        if (drv_in[i][18:16] <= 3'd4) mq[i].push_back('{dest: drv_in[i][18:16], data: drv_in[i][15:0]});
        else if (mdrop < DMAX) mdrop++;
      end
    end
  endfunction

  // Monitor: after each edge, pop/compare every newly presented packet.
  bit          prev_v [5];
  logic [17:0] prev_o [5];
  always @(posedge clk) begin
    bit v;
    bit mbusy;
    logic [17:0] e;
    #1;
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) prev_v[k] = 0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        v = (dut_out[k][17:16] != 2'b00);
        if (v && (!prev_v[k] || drv_rdy[k])) begin
          if (expq[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected k=%0d actual=%h expected=none t=%0t", k, dut_out[k], $time);
          end else begin
            e = expq[k].pop_front();
            chk($sformatf("out_n%0d", k), 32'(dut_out[k]), 32'(e));
          end
        end else if (v) begin
          chk($sformatf("hold_n%0d", k), 32'(dut_out[k]), 32'(prev_o[k]));
        end else if (prev_v[k] && !drv_rdy[k]) begin
          chk($sformatf("held_lost_n%0d", k), 32'(dut_out[k]), 32'(prev_o[k]));
        end
        if (expq[k].size() != 0) begin
          checks++;
          failures++;
          $display("FAIL out_late k=%0d actual=%h expected=%h t=%0t", k, dut_out[k], expq[k][0], $time);
          expq[k].delete();
        end
        prev_v[k] = v;
        prev_o[k] = dut_out[k];
      end
      mbusy = 0;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("in_rdy_n%0d", i), 32'(dut_irdy[i]), 32'(mq[i].size() < DEPTH));
        if (mq[i].size() > 0) mbusy = 1;
      end
      for (int k = 0; k < 5; k++) if (mslot[k]) mbusy = 1;
      chk("busy", 32'(bus.busy), 32'(mbusy));
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(mdrop));
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) drv_in[i] = 20'h0;
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) chk($sformatf("rst_out_n%0d", k), 32'(dut_out[k]), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_in_rdy_n%0d", i), 32'(dut_irdy[i]), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
    idle_inputs();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] d;
    idle_inputs();
    for (int k = 0; k < 5; k++) drv_rdy[k] = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Randomized mixed traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        d = ($urandom_range(15) < 14) ? 3'($urandom_range(4)) : 3'($urandom_range(7, 5));
        drv_in[i] = {($urandom_range(9) < 6) ? 1'b1 : 1'b0, d, 16'($urandom)};
      end
      for (int k = 0; k < 5; k++) drv_rdy[k] = ($urandom_range(9) < 6) ? 1'b1 : 1'b0;
      step();
    end

    // Reset with traffic in flight, then nothing queued may emerge.
    do_reset();
    for (int k = 0; k < 5; k++) drv_rdy[k] = 1'b1;
    for (int c = 0; c < 6; c++) step();

    // Single packet, input 2 to output 1.
    drv_in[2] = 20'h9_1234;
    step();
    idle_inputs();
    step();
    chk("single_out_n1", 32'(dut_out[1]), 32'h1_1234);
    step();
    chk("single_drain", 32'(dut_out[1]), 32'h0);
    chk("single_busy", 32'(bus.busy), 32'h0);

    // Four-way contention on output 3.
    do_reset();
    for (int k = 0; k < 5; k++) drv_rdy[k] = 1'b1;
    for (int i = 0; i < 4; i++) drv_in[i] = {1'b1, 3'd3, 16'h00A0 + 16'(i)};
    step();
    idle_inputs();
    step();
    chk("contend_0", 32'(dut_out[3]), 32'h2_00A0);
    step();
    chk("contend_1", 32'(dut_out[3]), 32'h2_00A1);
    step();
    chk("contend_2", 32'(dut_out[3]), 32'h2_00A2);
    step();
    chk("contend_3", 32'(dut_out[3]), 32'h1_00A3);
    step();
    chk("contend_idle", 32'(dut_out[3]), 32'h0);

    // Backpressure on output 0 with three packets from input 0.
    drv_rdy[0] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drv_in[0] = {1'b1, 3'd0, 16'hB000 + 16'(p)};
      step();
    end
    idle_inputs();
    chk("bp_held", 32'(dut_out[0]), 32'h1_B000);
    chk("bp_full", 32'(dut_irdy[0]), 32'h0);
    step();
    chk("bp_still_held", 32'(dut_out[0]), 32'h1_B000);
    drv_rdy[0] = 1'b1;
    step();
    chk("bp_rel_1", 32'(dut_out[0]), 32'h1_B001);
    step();
    chk("bp_rel_2", 32'(dut_out[0]), 32'h1_B002);
    step();
    chk("bp_rel_idle", 32'(dut_out[0]), 32'h0);

    // Illegal destinations: two in one edge, then force saturation.
    do_reset();
    drv_in[0] = {1'b1, 3'd6, 16'h1111};
    drv_in[1] = {1'b1, 3'd6, 16'h2222};
    step();
    idle_inputs();
    chk("drop_two", 32'(bus.drop_cnt), 32'd2);
    step();
    for (int k = 0; k < 5; k++) chk($sformatf("drop_no_out_n%0d", k), 32'(dut_out[k]), 32'h0);
    for (int c = 0; c < 75; c++) begin
      for (int i = 0; i < 4; i++) drv_in[i] = {1'b1, 3'd7, 16'($urandom)};
      step();
    end
    idle_inputs();
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // Full parallel throughput, input i to output i.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < 4; i++) drv_in[i] = {1'b1, 3'(i), 16'($urandom)};
      step();
      if (c >= 2) for (int k = 0; k < 4; k++) chk($sformatf("tput_cond_n%0d", k), 32'(dut_out[k][17:16]), 32'h1);
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) step();
    chk("final_busy", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
